// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM register stage with a 2-entry skid buffer and branch redirect.
// Define EXMEM_FWD_EN to add the fwd_valid/fwd_rd/fwd_data bypass outputs.
module ex_mem_stage #(
  parameter int XLEN = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_result,
  input  logic                  in_zero,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic [XLEN-1:0]       in_store_data,
  input  logic                  in_branch,
  input  logic [XLEN-1:0]       in_br_target,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_result,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic [XLEN-1:0]       out_store_data,
  output logic                  br_taken,
  output logic [XLEN-1:0]       br_target
`ifdef EXMEM_FWD_EN
  ,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]       fwd_data
`endif
);
  typedef struct packed {
    logic [XLEN-1:0]       result;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic [XLEN-1:0]       store_data;
  } entry_t;
  entry_t main_q, skid_q, in_e;
  logic main_valid, skid_valid, accept, xfer, main_free, br_hit;
  assign in_e = {in_result, in_rd, in_reg_write, in_mem_read, in_mem_write, in_store_data};
  assign in_ready = !skid_valid;
  assign accept = in_valid & in_ready;
  assign xfer = main_valid & out_ready;
  assign main_free = !main_valid | xfer;
  assign br_hit = !flush & accept & in_branch & in_zero;
  assign out_valid = main_valid;
  assign out_result = main_q.result;
  assign out_rd = main_q.rd;
  assign out_reg_write = main_q.reg_write;
  assign out_mem_read = main_q.mem_read;
  assign out_mem_write = main_q.mem_write;
  assign out_store_data = main_q.store_data;
`ifdef EXMEM_FWD_EN
  assign fwd_valid = main_valid & main_q.reg_write & !main_q.mem_read & (main_q.rd != '0);
  assign fwd_rd = main_q.rd;
  assign fwd_data = main_q.result;
`endif
  // An accept while skid is full is impossible (in_ready=0), so skid always drains into main first.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      br_taken <= 1'b0;
      br_target <= '0;
    end else begin
      br_taken <= br_hit;
      if (br_hit) br_target <= in_br_target;
      if (!flush && main_free && (skid_valid || accept)) main_q <= skid_valid ? skid_q : in_e;
      if (!flush && !main_free && accept) skid_q <= in_e;
      main_valid <= !flush && (main_free ? (skid_valid || accept) : 1'b1);
      skid_valid <= !flush && !main_free && (skid_valid || accept);
    end
  end
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: scoreboard bench for ex_mem_stage; stimulus pushes, negedge monitor pops.
module tb_ex_mem_stage;
  logic clk = 0, rst, flush, in_valid, in_ready, in_zero, in_reg_write, in_mem_read, in_mem_write, in_branch;
  logic out_valid, out_ready, out_reg_write, out_mem_read, out_mem_write, br_taken;
  logic [31:0] in_result, in_store_data, in_br_target, out_result, out_store_data, br_target;
  logic [4:0] in_rd, out_rd;
`ifdef EXMEM_FWD_EN
  logic fwd_valid;
  logic [4:0] fwd_rd;
  logic [31:0] fwd_data;
`endif
  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic [31:0] store_data;
  } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0, ntx = 0;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_zero(in_zero), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_store_data(in_store_data),
    .in_branch(in_branch), .in_br_target(in_br_target), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_store_data(out_store_data),
    .br_taken(br_taken), .br_target(br_target)
`ifdef EXMEM_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t got;
      got = {out_result, out_rd, out_reg_write, out_mem_read, out_store_data};
      checks++;
      ntx++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected: got %h, required none", got);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL xfer_data: got %h, required %h", got, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic offer(input logic [31:0] res, input logic [4:0] rd, input logic rw, input logic mr,
                       input logic br, input logic z, input logic [31:0] tgt);
    in_valid = 1;
    in_result = res;
    in_rd = rd;
    in_reg_write = rw;
    in_mem_read = mr;
    in_mem_write = 0;
    in_store_data = res ^ 32'hFFFF;
    in_branch = br;
    in_zero = z;
    in_br_target = tgt;
    if (in_ready && !flush) sb.push_back({res, rd, rw, mr, res ^ 32'hFFFF});
    step();
    in_valid = 0;
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_result = 0; in_rd = 0; in_zero = 0;
    in_reg_write = 0; in_mem_read = 0; in_mem_write = 0; in_store_data = 0; in_branch = 0; in_br_target = 0;
    step(); step();
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_br_taken", {31'b0, br_taken}, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_br_target", br_target, 0);
    rst = 0;
    // single entry, latency 1
    out_ready = 1;
    offer(32'h7, 5, 1, 0, 0, 0, 0);
    chk("lat_out_valid", {31'b0, out_valid}, 1);
    chk("lat_out_result", out_result, 32'h7);
    chk("lat_out_rd", {27'b0, out_rd}, 5);
    // streaming
    for (int i = 0; i < 10; i++) begin
      chk("stream_in_ready", {31'b0, in_ready}, 1);
      offer(32'h100 + i, 5'(i + 1), 1, 0, 0, 0, 0);
    end
    step(); step();
    chk("stream_ntx", ntx, 11);
    chk("stream_empty", {31'b0, out_valid}, 0);
    // back-pressure fills skid
    out_ready = 0;
    offer(32'h11, 1, 1, 0, 0, 0, 0);
    chk("bp_in_ready_one", {31'b0, in_ready}, 1);
    offer(32'h22, 2, 1, 0, 0, 0, 0);
    chk("bp_in_ready_full", {31'b0, in_ready}, 0);
    offer(32'h33, 3, 1, 0, 0, 0, 0);
    chk("bp_c_not_taken_ready", {31'b0, in_ready}, 0);
    chk("bp_head_stable", out_result, 32'h11);
    out_ready = 1;
    step();
    chk("bp_drain_ready", {31'b0, in_ready}, 1);
    chk("bp_drain_head", out_result, 32'h22);
    step();
    chk("bp_sb_empty", sb.size(), 0);
    // branch pulse under back-pressure
    out_ready = 0;
    offer(32'h55, 0, 0, 0, 1, 1, 32'h100);
    chk("br_taken_pulse", {31'b0, br_taken}, 1);
    chk("br_target", br_target, 32'h100);
    step();
    chk("br_taken_one_cycle", {31'b0, br_taken}, 0);
    offer(32'h66, 0, 0, 0, 1, 0, 32'h200);
    chk("br_not_taken", {31'b0, br_taken}, 0);
    chk("br_target_hold", br_target, 32'h100);
    out_ready = 1;
    step(); step();
    chk("br_sb_empty", sb.size(), 0);
    // flush with two entries buffered
    out_ready = 0;
    offer(32'hA1, 1, 1, 0, 0, 0, 0);
    offer(32'hA2, 2, 1, 0, 0, 0, 0);
    flush = 1;
    offer(32'hDEAD, 7, 1, 0, 0, 0, 0);
    flush = 0;
    sb.delete();
    chk("flush2_out_valid", {31'b0, out_valid}, 0);
    chk("flush2_in_ready", {31'b0, in_ready}, 1);
    // flush while an accept is offered
    offer(32'hB1, 1, 1, 0, 0, 0, 0);
    flush = 1;
    offer(32'hBEEF, 9, 1, 0, 1, 1, 32'h300);
    flush = 0;
    sb.delete();
    chk("flush1_out_valid", {31'b0, out_valid}, 0);
    chk("flush1_no_branch", {31'b0, br_taken}, 0);
    out_ready = 1;
    step(); step(); step();
    chk("flush_nothing_out", {31'b0, out_valid}, 0);
`ifdef EXMEM_FWD_EN
    out_ready = 0;
    offer(32'hABCD, 3, 1, 0, 0, 0, 0);
    chk("fwd_valid", {31'b0, fwd_valid}, 1);
    chk("fwd_rd", {27'b0, fwd_rd}, 3);
    chk("fwd_data", fwd_data, 32'hABCD);
    out_ready = 1;
    step();
    out_ready = 0;
    offer(32'h1234, 0, 1, 0, 0, 0, 0);
    chk("fwd_rd0", {31'b0, fwd_valid}, 0);
    out_ready = 1;
    step();
    out_ready = 0;
    offer(32'h5678, 3, 1, 1, 0, 0, 0);
    chk("fwd_load", {31'b0, fwd_valid}, 0);
    out_ready = 1;
    step();
`endif
    step();
    chk("final_sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
